// File: rtl/pickup_fifo.sv
// Frame-tagging FWFT circular FIFO behind the LVDS pickup receiver.
// Latency: a word accepted on one edge is visible at the output after that edge.
// Backpressure: out_ready stalls reads; writes while full are dropped and counted.
module pickup_fifo #(
   parameter int MAXBIT    = 12,
   parameter int ADDR_W    = 4,
   parameter int FRAME_LEN = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              in_valid,
   input  logic [MAXBIT:1]   in_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [MAXBIT:1]   out_data,
   output logic              out_last,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic [7:0]        drop_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int FW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [FW-1:0]   FCNT_LAST = FW'(FRAME_LEN - 1);
   localparam logic [ADDR_W:0] LVL_FULL  = (ADDR_W + 1)'(DEPTH);

   typedef struct packed {
      logic              last;
      logic [MAXBIT-1:0] dat;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          rd_ent;
   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic [FW-1:0]   fcnt;
   logic            empty;
   logic            full;
   logic            rd_fire;
   logic            in_fire;
   logic            wr_acc;
   logic            drop;
   logic            frame_end;

   assign level     = wr_ptr - rd_ptr;
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (level == LVL_FULL);
   assign out_valid = !empty;
   assign rd_fire   = out_valid & out_ready;
   assign in_fire   = enable & in_valid;
   // A full FIFO still takes the word when the same cycle frees a slot.
   assign wr_acc    = in_fire & (!full | rd_fire);
   assign drop      = in_fire & full & !rd_fire;
   assign frame_end = (fcnt == FCNT_LAST);

   assign rd_ent    = mem[rd_ptr[ADDR_W-1:0]];
   assign out_data  = rd_ent.dat;
   assign out_last  = out_valid & rd_ent.last;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[ADDR_W-1:0]] <= '{last: frame_end, dat: in_data};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Frame position follows the sensor, so dropped words still advance it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fcnt     <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (!enable) begin
         fcnt     <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (in_fire) fcnt <= frame_end ? '0 : fcnt + 1'b1;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_pickup_fifo.sv
// Randomized and directed bench for pickup_fifo against a queue-based model.
module tb_pickup_fifo;
   localparam int MAXBIT    = 12;
   localparam int ADDR_W    = 4;
   localparam int FRAME_LEN = 8;
   localparam int DEPTH     = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic              in_valid;
   logic [MAXBIT:1]   in_data;
   logic              out_ready;
   logic              out_valid;
   logic [MAXBIT:1]   out_data;
   logic              out_last;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic [7:0]        drop_cnt;

   pickup_fifo #(.MAXBIT(MAXBIT), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN)) dut (
      .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: stored words as {last, data}, plus frame/error state.
   logic [MAXBIT:0] mq[$];
   int              m_fcnt = 0;
   bit              m_ovf  = 0;
   int              m_drop = 0;
   int              rx_cnt = 0;
   logic [MAXBIT:1] last_words[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_fcnt = 0;
      m_ovf  = 0;
      m_drop = 0;
   endtask

   // Drive one cycle, compare outputs mid-cycle, then advance the model.
   task automatic cycle(input bit en, input bit v, input logic [MAXBIT:1] d, input bit rdy);
      bit rd;
      bit full;
      enable    = en;
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("level", 32'(level), 32'(mq.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (mq.size() != 0) begin
         check("out_data", 32'(out_data), 32'(mq[0][MAXBIT-1:0]));
         check("out_last", 32'(out_last), 32'(mq[0][MAXBIT]));
      end
      rd   = (mq.size() != 0) && rdy;
      full = (mq.size() == DEPTH);
      if (rd) begin
         if (out_last) last_words.push_back(out_data);
         void'(mq.pop_front());
         rx_cnt++;
      end
      if (en && v) begin
         if (!full || rd) mq.push_back({m_fcnt == FRAME_LEN - 1, d});
         else begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
         end
         m_fcnt = (m_fcnt + 1) % FRAME_LEN;
      end
      if (!en) begin
         m_fcnt = 0;
         m_ovf  = 0;
         m_drop = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input bit en);
      for (int k = 0; k < 200 && mq.size() != 0; k++) cycle(en, 1'b0, '0, 1'b1);
      check("drain_empty", 32'(level), 32'd0);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // T1: fill to capacity with no reads
      for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b1, MAXBIT'(i), 1'b0);
      check("t1_level", 32'(level), 32'd16);
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_out_data", 32'(out_data), 32'h001);
      check("t1_overflow", 32'(overflow), 32'd0);

      // T2: write while full drops the word
      cycle(1'b1, 1'b1, 12'h011, 1'b0);
      check("t2_overflow", 32'(overflow), 32'd1);
      check("t2_drop_cnt", 32'(drop_cnt), 32'd1);
      check("t2_level", 32'(level), 32'd16);

      // T3: full-and-read accepts the new word
      cycle(1'b1, 1'b1, 12'h0AA, 1'b1);
      check("t3_level", 32'(level), 32'd16);
      check("t3_out_data", 32'(out_data), 32'h002);
      check("t3_drop_cnt", 32'(drop_cnt), 32'd1);

      // Drain with enable low: writes ignored, error state cleared
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, MAXBIT'($urandom), 1'b1);
      check("en_lo_level", 32'(level), 32'd0);
      check("en_lo_overflow", 32'(overflow), 32'd0);
      check("en_lo_drop_cnt", 32'(drop_cnt), 32'd0);

      // T4: frame tagging on a streamed run
      last_words.delete();
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, MAXBIT'(12'h101 + i), 1'b1);
      drain(1'b1);
      check("t4_last_count", 32'(last_words.size()), 32'd2);
      if (last_words.size() == 2) begin
         check("t4_last0", 32'(last_words[0]), 32'h108);
         check("t4_last1", 32'(last_words[1]), 32'h110);
      end

      // T5: 40 words with random backpressure, no loss
      begin
         int sent = 0;
         rx_cnt = 0;
         for (int k = 0; k < 2000 && sent < 40; k++) begin
            bit v;
            v = ($urandom_range(0, 1) == 1) && (mq.size() < DEPTH);
            cycle(1'b1, v, MAXBIT'(12'h200 + sent), $urandom_range(0, 1) == 1);
            if (v) sent++;
         end
         check("t5_sent", 32'(sent), 32'd40);
         for (int k = 0; k < 500 && mq.size() != 0; k++)
            cycle(1'b1, 1'b0, '0, $urandom_range(0, 1) == 1);
         check("t5_received", 32'(rx_cnt), 32'd40);
         check("t5_level", 32'(level), 32'd0);
         check("t5_overflow", 32'(overflow), 32'd0);
      end

      // Random mix: drops, enable toggles, simultaneous read/write
      for (int k = 0; k < 600; k++)
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
               MAXBIT'($urandom), $urandom_range(0, 2) == 0);

      // drop_cnt saturation
      drain(1'b1);
      cycle(1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 16 + 270; k++) cycle(1'b1, 1'b1, MAXBIT'($urandom), 1'b0);
      check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
      check("sat_overflow", 32'(overflow), 32'd1);

      // T6: async reset mid-stream discards contents and realigns frames
      drain(1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, MAXBIT'(12'h300 + i), 1'b0);
      check("t6_pre_level", 32'(level), 32'd5);
      reset = 1'b1;
      #1;
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_level", 32'(level), 32'd0);
      check("t6_out_last", 32'(out_last), 32'd0);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      last_words.delete();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, MAXBIT'(12'h400 + i), 1'b1);
      drain(1'b1);
      check("t6_last_count", 32'(last_words.size()), 32'd1);
      if (last_words.size() == 1) check("t6_last_word", 32'(last_words[0]), 32'h407);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
